fiber_iq_xmit: RTL and testbench

//  Transmit end of the fiber I/Q link consumed by llrf_dsp (iq_recv/qsync_rx).

---
 rtl/fiber_iq_pkg.sv | 14 +
 rtl/fiber_iq_hold.sv | 63 ++++++
 rtl/fiber_iq_xmit.sv | 86 ++++++++
 tb/tb_fiber_iq_xmit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fiber_iq_pkg.sv
// Shared fiber I/Q link constants: word width, frame length, slot parity and sync slot.
// The receiver side uses the same values so both ends agree on slot meaning.
package fiber_iq_pkg;
    localparam int FIBER_DW        = 17;
    localparam int FIBER_FRAME_LEN = 16;
    localparam int FIBER_CW        = $clog2(FIBER_FRAME_LEN);
    // Even slots carry Q and odd slots carry I, matching the receiver's state[0] ? I : Q.
    localparam bit SLOT_Q_EVEN     = 1'b1;
    localparam int QSYNC_SLOT      = 0;

    function automatic logic slot_is_i(input logic slot_lsb);
        return SLOT_Q_EVEN ? slot_lsb : ~slot_lsb;
    endfunction
endpackage

// File: rtl/fiber_iq_hold.sv
// Double buffer for (I,Q) pairs: a holding register filled by the source and a tx
// register swapped in at frame boundaries, plus the sticky overrun/underrun flags.
module fiber_iq_hold #(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_i,
    input  logic [DW-1:0] in_q,
    input  logic          in_valid,
    input  logic          load,
    input  logic          clear,
    input  logic          ovr_en,
    input  logic [DW-1:0] ovr_i,
    input  logic [DW-1:0] ovr_q,
    output logic [DW-1:0] tx_i,
    output logic [DW-1:0] tx_q,
    output logic          overrun,
    output logic          underrun
);
    logic [DW-1:0] hold_i, hold_q;
    logic          hold_full;
    logic          ovr_set, und_set;

    // A pair arriving on the load cycle into an empty hold is sent straight to tx,
    // so a strobe at the last slot reaches the very next frame.
    assign ovr_set = in_valid && hold_full && !load;
    assign und_set = load && !hold_full && !in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_i    <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            tx_i      <= '0;
            tx_q      <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (in_valid) begin
                hold_i <= in_i;
                hold_q <= in_q;
            end
            if (load) begin
                hold_full <= hold_full && in_valid;
                if (ovr_en) begin
                    tx_i <= ovr_i;
                    tx_q <= ovr_q;
                end else if (hold_full) begin
                    tx_i <= hold_i;
                    tx_q <= hold_q;
                end else if (in_valid) begin
                    tx_i <= in_i;
                    tx_q <= in_q;
                end
            end else if (in_valid) begin
                hold_full <= 1'b1;
            end
            overrun  <= ovr_set | (overrun  & ~clear);
            underrun <= und_set | (underrun & ~clear);
        end
    end
endmodule

// File: rtl/fiber_iq_xmit.sv
// Fiber I/Q transmitter: free-running slot framer and Q/I word mux over fiber_iq_hold.
// Optional FIBER_IQ_TEST_PATTERN_EN adds a test_mode input that sends a per-frame ramp.
module fiber_iq_xmit
    import fiber_iq_pkg::*;
#(
    parameter int DW        = FIBER_DW,
    parameter int FRAME_LEN = FIBER_FRAME_LEN,
    parameter int CW        = FIBER_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] in_i,
    input  logic [DW-1:0] in_q,
    input  logic          in_valid,
    input  logic          clear,
`ifdef FIBER_IQ_TEST_PATTERN_EN
    input  logic          test_mode,
`endif
    output logic [DW-1:0] iq_xmit,
    output logic          qsync_tx,
    output logic          overrun,
    output logic          underrun,
    output logic [15:0]   frame_count
);
    logic [CW-1:0] slot;
    logic          load;
    logic [DW-1:0] tx_i, tx_q;
    logic          ovr_en;
    logic [DW-1:0] ovr_i, ovr_q;

    assign load = (slot == CW'(FRAME_LEN - 1));

`ifdef FIBER_IQ_TEST_PATTERN_EN
    logic [DW-1:0] ramp;
    assign ovr_en = test_mode;
    assign ovr_i  = ramp;
    assign ovr_q  = ~ramp;

    always_ff @(posedge clk) begin
        if (rst)
            ramp <= '0;
        else if (load && test_mode)
            ramp <= ramp + 1'b1;
    end
`else
    assign ovr_en = 1'b0;
    assign ovr_i  = '0;
    assign ovr_q  = '0;
`endif

    fiber_iq_hold #(.DW(DW)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_i     (in_i),
        .in_q     (in_q),
        .in_valid (in_valid),
        .load     (load),
        .clear    (clear),
        .ovr_en   (ovr_en),
        .ovr_i    (ovr_i),
        .ovr_q    (ovr_q),
        .tx_i     (tx_i),
        .tx_q     (tx_q),
        .overrun  (overrun),
        .underrun (underrun)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot        <= '0;
            iq_xmit     <= '0;
            qsync_tx    <= 1'b0;
            frame_count <= '0;
        end else begin
            slot     <= slot + 1'b1;
            qsync_tx <= (slot == CW'(QSYNC_SLOT));
            if (!enable)
                iq_xmit <= '0;
            else
                iq_xmit <= slot_is_i(slot[0]) ? tx_i : tx_q;
            if (load)
                frame_count <= frame_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fiber_iq_xmit.sv
// Directed self-checking bench for fiber_iq_xmit (default build, test pattern off).
module tb_fiber_iq_xmit;
    logic        clk = 1'b0;
    logic        rst, enable, in_valid, clear;
    logic [16:0] in_i, in_q;
    logic [16:0] iq_xmit;
    logic        qsync_tx, overrun, underrun;
    logic [15:0] frame_count;
`ifdef FIBER_IQ_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int slot   = 0;

    fiber_iq_xmit dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_i        (in_i),
        .in_q        (in_q),
        .in_valid    (in_valid),
        .clear       (clear),
`ifdef FIBER_IQ_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .iq_xmit     (iq_xmit),
        .qsync_tx    (qsync_tx),
        .overrun     (overrun),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; slot tracks the DUT slot counter value for the coming edge.
    task automatic tick();
        @(posedge clk);
        slot = rst ? 0 : (slot + 1) % 16;
        #1;
    endtask

    task automatic run_to_slot(input int s);
        for (int n = 0; n < 16 && slot != s; n++) tick();
    endtask

    task automatic send(input logic [16:0] i, input logic [16:0] q);
        in_i = i; in_q = q; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; clear = 1'b0; in_i = '0; in_q = '0;
        repeat (5) tick();
        checks++;
        if (iq_xmit !== 17'd0 || qsync_tx !== 1'b0 || overrun !== 1'b0 ||
            underrun !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: word=%0h qsync=%b ovr=%b und=%b fc=%0d, want all 0",
                     iq_xmit, qsync_tx, overrun, underrun, frame_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_framing();
        for (int j = 1; j <= 48; j++) begin
            tick();
            checks++;
            if (qsync_tx !== ((j - 1) % 16 == 0) || iq_xmit !== 17'd0) begin
                errors++;
                $display("FAIL idle_frame cycle %0d: qsync=%b word=%0h, want qsync=%b word=0",
                         j, qsync_tx, iq_xmit, ((j - 1) % 16 == 0));
            end
            if (j == 15 || j == 16) begin
                checks++;
                if (underrun !== (j == 16)) begin
                    errors++;
                    $display("FAIL idle_underrun cycle %0d: got %b want %b", j, underrun, (j == 16));
                end
            end
            if (j % 16 == 0) begin
                checks++;
                if (frame_count !== 16'(j / 16)) begin
                    errors++;
                    $display("FAIL frame_count cycle %0d: got %0d want %0d", j, frame_count, j / 16);
                end
            end
        end
    endtask

    task automatic test_last_slot_latency();
        run_to_slot(15);
        send(17'd3000, 17'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (qsync_tx !== (k == 0) || iq_xmit !== ((k % 2) ? 17'd3000 : 17'd0)) begin
                errors++;
                $display("FAIL latency word %0d: qsync=%b word=%0d, want qsync=%b word=%0d",
                         k, qsync_tx, iq_xmit, (k == 0), (k % 2) ? 3000 : 0);
            end
        end
    endtask

    task automatic test_overrun();
        logic signed [16:0] neg200;
        neg200 = -17'sd200;
        run_to_slot(0);
        clear = 1'b1; tick(); clear = 1'b0;
        run_to_slot(2);
        send(17'd100, -17'sd100);
        run_to_slot(5);
        clear = 1'b1;
        send(17'd200, neg200);
        clear = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set (with clear): got %b want 1", overrun);
        end
        run_to_slot(15);
        tick();
        tick();
        checks++;
        if (qsync_tx !== 1'b1 || iq_xmit !== neg200) begin
            errors++;
            $display("FAIL overrun_q: qsync=%b word=%0h, want 1 %0h", qsync_tx, iq_xmit, neg200);
        end
        tick();
        checks++;
        if (iq_xmit !== 17'd200) begin
            errors++;
            $display("FAIL overrun_i: got %0d want 200", iq_xmit);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_no_underrun: got %b want 0", underrun);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
    endtask

    task automatic test_load_collision();
        run_to_slot(8);
        send(17'd111, 17'd222);
        run_to_slot(15);
        send(17'd333, 17'd444);
        tick();
        checks++;
        if (qsync_tx !== 1'b1 || iq_xmit !== 17'd222) begin
            errors++;
            $display("FAIL collide_q_old: qsync=%b word=%0d, want 1 222", qsync_tx, iq_xmit);
        end
        tick();
        checks++;
        if (iq_xmit !== 17'd111) begin
            errors++;
            $display("FAIL collide_i_old: got %0d want 111", iq_xmit);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL collide_overrun: got %b want 0", overrun);
        end
        run_to_slot(15);
        tick();
        tick();
        checks++;
        if (iq_xmit !== 17'd444) begin
            errors++;
            $display("FAIL collide_q_new: got %0d want 444", iq_xmit);
        end
        tick();
        checks++;
        if (iq_xmit !== 17'd333 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL collide_i_new: word=%0d und=%b, want 333 0", iq_xmit, underrun);
        end
    endtask

    task automatic test_enable_and_reset();
        run_to_slot(5);
        enable = 1'b0;
        tick();
        checks++;
        if (iq_xmit !== 17'd0) begin
            errors++;
            $display("FAIL disable_word: got %0d want 0", iq_xmit);
        end
        run_to_slot(0);
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (qsync_tx !== (k == 0) || iq_xmit !== 17'd0) begin
                errors++;
                $display("FAIL disable_frame word %0d: qsync=%b word=%0d, want %b 0",
                         k, qsync_tx, iq_xmit, (k == 0));
            end
        end
        enable = 1'b1;
        run_to_slot(3);
        send(17'd1, 17'd2);
        send(17'd3, 17'd4);
        checks++;
        if (overrun !== 1'b1 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flags: ovr=%b und=%b, want 1 1", overrun, underrun);
        end
        run_to_slot(7);
        rst = 1'b1;
        tick();
        checks++;
        if (iq_xmit !== 17'd0 || qsync_tx !== 1'b0 || overrun !== 1'b0 ||
            underrun !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL midframe_reset: word=%0h qsync=%b ovr=%b und=%b fc=%0d, want all 0",
                     iq_xmit, qsync_tx, overrun, underrun, frame_count);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (qsync_tx !== 1'b1 || iq_xmit !== 17'd0) begin
            errors++;
            $display("FAIL reset_restart: qsync=%b word=%0d, want 1 0", qsync_tx, iq_xmit);
        end
        tick();
        checks++;
        if (qsync_tx !== 1'b0 || iq_xmit !== 17'd0) begin
            errors++;
            $display("FAIL reset_discard: qsync=%b word=%0d, want 0 0", qsync_tx, iq_xmit);
        end
    endtask

    initial begin
        test_reset();
        test_idle_framing();
        test_last_slot_latency();
        test_overrun();
        test_load_collision();
        test_enable_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
